// File: rtl/ctrl_src_arbiter.sv
// Control-source arbiter: hands the counter/shift-register datapath between the local
// board inputs and the debug VIO via drain -> flush -> grant. Optional macro: LOCAL_DEBOUNCE_EN.
module ctrl_src_arbiter #(
  parameter int NB_SW         = 4,
  parameter int FLUSH_CYC     = 4,
  parameter int DRAIN_TIMEOUT = 1023,
  parameter int NB_TO         = 10,
  parameter int STABLE_CYC    = 255
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic [NB_SW-1:0] i_sw_local,
  input  logic             i_reset_local,
  input  logic             i_sel_debug,
  input  logic [NB_SW-1:0] i_sw_debug,
  input  logic             i_reset_debug,
  input  logic             i_valid,
  output logic [NB_SW-1:0] o_sw,
  output logic             o_dp_reset,
  output logic [1:0]       o_grant,
  output logic             o_busy
);

  localparam int NB_LOC = NB_SW + 1;

  typedef enum logic [1:0] {
    ST_LOCAL = 2'd0,
    ST_DEBUG = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [NB_TO-1:0]  cnt;
  logic [NB_TO-1:0]  cnt_n;
  logic [NB_SW-1:0]  sw_n;
  logic              dp_reset_n;
  logic [1:0]        grant_n;
  logic              busy_n;

  logic [NB_LOC-1:0] sync_meta;
  logic [NB_LOC-1:0] sync_out;
  logic [NB_LOC-1:0] loc_filt;
  logic [NB_SW-1:0]  loc_sw;
  logic              loc_rst;

  // Local button and switches are bundled so they share one two-stage synchronizer.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      sync_meta <= '0;
      sync_out  <= '0;
    end else begin
      sync_meta <= {i_reset_local, i_sw_local};
      sync_out  <= sync_meta;
    end
  end

`ifdef LOCAL_DEBOUNCE_EN
  localparam int NB_DB = (STABLE_CYC < 2) ? 1 : $clog2(STABLE_CYC + 1);

  logic [NB_DB-1:0] db_cnt [NB_LOC];

  // Each bit counts consecutive samples that disagree with its filtered value and only
  // adopts the new level after a full stable window.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      loc_filt <= '0;
      for (int i = 0; i < NB_LOC; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NB_LOC; i++) begin
        if (sync_out[i] == loc_filt[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == NB_DB'(STABLE_CYC - 1)) begin
          loc_filt[i] <= sync_out[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign loc_filt = sync_out;
`endif

  assign loc_sw  = loc_filt[NB_SW-1:0];
  assign loc_rst = loc_filt[NB_SW];

  // Reset is treated as a flush so the datapath is always cleared at startup.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state      <= ST_FLUSH;
      cnt        <= '0;
      o_sw       <= '0;
      o_dp_reset <= 1'b1;
      o_grant    <= 2'b00;
      o_busy     <= 1'b1;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      o_sw       <= sw_n;
      o_dp_reset <= dp_reset_n;
      o_grant    <= grant_n;
      o_busy     <= busy_n;
    end
  end

  // Next state first, then the registered outputs are derived from the state being entered,
  // so outputs always line up with the state register.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    sw_n       = o_sw;
    dp_reset_n = o_dp_reset;
    grant_n    = o_grant;
    busy_n     = o_busy;

    case (state)
      ST_LOCAL: begin
        if (i_sel_debug) begin
          state_n = ST_DRAIN;
          cnt_n   = '0;
        end
      end
      ST_DEBUG: begin
        if (!i_sel_debug) begin
          state_n = ST_DRAIN;
          cnt_n   = '0;
        end
      end
      ST_DRAIN: begin
        if (i_valid || (cnt == NB_TO'(DRAIN_TIMEOUT))) begin
          state_n = ST_FLUSH;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_FLUSH: begin
        if (cnt == NB_TO'(FLUSH_CYC - 1)) begin
          state_n = i_sel_debug ? ST_DEBUG : ST_LOCAL;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = ST_FLUSH;
        cnt_n   = '0;
      end
    endcase

    case (state_n)
      ST_LOCAL: begin
        sw_n       = loc_sw;
        dp_reset_n = loc_rst;
        grant_n    = 2'b01;
        busy_n     = 1'b0;
      end
      ST_DEBUG: begin
        sw_n       = i_sw_debug;
        dp_reset_n = i_reset_debug;
        grant_n    = 2'b10;
        busy_n     = 1'b0;
      end
      ST_DRAIN: begin
        dp_reset_n = 1'b0;
        grant_n    = 2'b00;
        busy_n     = 1'b1;
      end
      default: begin
        sw_n       = i_sel_debug ? i_sw_debug : loc_sw;
        dp_reset_n = 1'b1;
        grant_n    = 2'b00;
        busy_n     = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_ctrl_src_arbiter.sv
// Bench for ctrl_src_arbiter: hand-derived vector table plus corner-case sequences,
// with expected outputs queued at drive time and popped after each clock edge.
module tb_ctrl_src_arbiter;

  logic       clock = 1'b0;
  logic       i_reset = 1'b1;
  logic [3:0] i_sw_local = '0;
  logic       i_reset_local = 1'b0;
  logic       i_sel_debug = 1'b0;
  logic [3:0] i_sw_debug = '0;
  logic       i_reset_debug = 1'b0;
  logic       i_valid = 1'b0;
  logic [3:0] o_sw;
  logic       o_dp_reset;
  logic [1:0] o_grant;
  logic       o_busy;

  typedef struct {
    logic       rst;
    logic       sel;
    logic [3:0] sw_loc;
    logic       rst_loc;
    logic [3:0] sw_dbg;
    logic       rst_dbg;
    logic       valid;
    logic [3:0] exp_sw;
    logic       exp_dpr;
    logic [1:0] exp_grant;
  } vec_t;

  vec_t  vecs [37];
  vec_t  exp_q [$];
  int    n_compared = 0;
  int    n_mismatched = 0;
  int    step_idx = 0;
  string phase = "init";

  ctrl_src_arbiter dut (
    .clock         (clock),
    .i_reset       (i_reset),
    .i_sw_local    (i_sw_local),
    .i_reset_local (i_reset_local),
    .i_sel_debug   (i_sel_debug),
    .i_sw_debug    (i_sw_debug),
    .i_reset_debug (i_reset_debug),
    .i_valid       (i_valid),
    .o_sw          (o_sw),
    .o_dp_reset    (o_dp_reset),
    .o_grant       (o_grant),
    .o_busy        (o_busy)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(input logic rst, input logic sel, input logic [3:0] swl,
                              input logic rl, input logic [3:0] swd, input logic rd,
                              input logic v, input logic [3:0] esw, input logic edpr,
                              input logic [1:0] egr);
    vec_t r;
    r.rst = rst; r.sel = sel; r.sw_loc = swl; r.rst_loc = rl;
    r.sw_dbg = swd; r.rst_dbg = rd; r.valid = v;
    r.exp_sw = esw; r.exp_dpr = edpr; r.exp_grant = egr;
    return r;
  endfunction

  task automatic applyStimulus(input vec_t v);
    i_reset       = v.rst;
    i_sel_debug   = v.sel;
    i_sw_local    = v.sw_loc;
    i_reset_local = v.rst_loc;
    i_sw_debug    = v.sw_dbg;
    i_reset_debug = v.rst_dbg;
    i_valid       = v.valid;
    exp_q.push_back(v);
  endtask

  task automatic checkOutput();
    vec_t e;
    logic exp_busy;
    n_compared++;
    if (exp_q.size() == 0) begin
      n_mismatched++;
      $display("[TB] FAIL %s step %0d: scoreboard empty, no expected record", phase, step_idx);
    end else begin
      e = exp_q.pop_front();
      exp_busy = (e.exp_grant == 2'b00);
      if (o_sw !== e.exp_sw || o_dp_reset !== e.exp_dpr || o_grant !== e.exp_grant ||
          o_busy !== exp_busy) begin
        n_mismatched++;
        $display("[TB] FAIL %s step %0d: got sw=%b dpr=%b grant=%b busy=%b, expected sw=%b dpr=%b grant=%b busy=%b",
                 phase, step_idx, o_sw, o_dp_reset, o_grant, o_busy,
                 e.exp_sw, e.exp_dpr, e.exp_grant, exp_busy);
      end
    end
    step_idx++;
  endtask

  task automatic runVec(input vec_t v);
    applyStimulus(v);
    @(posedge clock);
    #1;
    checkOutput();
  endtask

  initial begin
    // Startup flush, local sync latency, local reset path, handover to debug,
    // debug reset path, and handover back to local with an entry-cycle i_valid.
    vecs[0]  = mk(1, 0, 4'b0101, 0, 4'b1010, 0, 0, 4'b0000, 1, 2'b00);
    vecs[1]  = mk(0, 0, 4'b0101, 0, 4'b1010, 0, 0, 4'b0000, 1, 2'b00);
    vecs[2]  = mk(0, 0, 4'b0101, 0, 4'b1010, 0, 0, 4'b0000, 1, 2'b00);
    vecs[3]  = mk(0, 0, 4'b0101, 0, 4'b1010, 0, 0, 4'b0101, 1, 2'b00);
    vecs[4]  = mk(0, 0, 4'b0101, 0, 4'b1010, 0, 0, 4'b0101, 0, 2'b01);
    vecs[5]  = mk(0, 0, 4'b0011, 0, 4'b1010, 0, 0, 4'b0101, 0, 2'b01);
    vecs[6]  = mk(0, 0, 4'b0011, 0, 4'b1010, 0, 0, 4'b0101, 0, 2'b01);
    vecs[7]  = mk(0, 0, 4'b0011, 0, 4'b1010, 0, 0, 4'b0011, 0, 2'b01);
    vecs[8]  = mk(0, 0, 4'b0011, 1, 4'b1010, 0, 0, 4'b0011, 0, 2'b01);
    vecs[9]  = mk(0, 0, 4'b0011, 1, 4'b1010, 0, 0, 4'b0011, 0, 2'b01);
    vecs[10] = mk(0, 0, 4'b0011, 0, 4'b1010, 0, 0, 4'b0011, 1, 2'b01);
    vecs[11] = mk(0, 0, 4'b0011, 0, 4'b1010, 0, 0, 4'b0011, 1, 2'b01);
    vecs[12] = mk(0, 0, 4'b0011, 0, 4'b1010, 0, 0, 4'b0011, 0, 2'b01);
    vecs[13] = mk(0, 1, 4'b0011, 0, 4'b1010, 0, 0, 4'b0011, 0, 2'b00);
    vecs[14] = mk(0, 1, 4'b0011, 0, 4'b1010, 0, 0, 4'b0011, 0, 2'b00);
    vecs[15] = mk(0, 1, 4'b0011, 0, 4'b1010, 0, 0, 4'b0011, 0, 2'b00);
    vecs[16] = mk(0, 1, 4'b0011, 0, 4'b1010, 0, 0, 4'b0011, 0, 2'b00);
    vecs[17] = mk(0, 1, 4'b0011, 0, 4'b1010, 0, 0, 4'b0011, 0, 2'b00);
    vecs[18] = mk(0, 1, 4'b0011, 0, 4'b1010, 0, 1, 4'b1010, 1, 2'b00);
    vecs[19] = mk(0, 1, 4'b0011, 0, 4'b1010, 0, 0, 4'b1010, 1, 2'b00);
    vecs[20] = mk(0, 1, 4'b0011, 0, 4'b1010, 0, 0, 4'b1010, 1, 2'b00);
    vecs[21] = mk(0, 1, 4'b0011, 0, 4'b1010, 0, 0, 4'b1010, 1, 2'b00);
    vecs[22] = mk(0, 1, 4'b0011, 0, 4'b1010, 0, 0, 4'b1010, 0, 2'b10);
    vecs[23] = mk(0, 1, 4'b0011, 1, 4'b1010, 0, 0, 4'b1010, 0, 2'b10);
    vecs[24] = mk(0, 1, 4'b0011, 1, 4'b1010, 0, 0, 4'b1010, 0, 2'b10);
    vecs[25] = mk(0, 1, 4'b0011, 0, 4'b1010, 0, 0, 4'b1010, 0, 2'b10);
    vecs[26] = mk(0, 1, 4'b0011, 0, 4'b1010, 0, 0, 4'b1010, 0, 2'b10);
    vecs[27] = mk(0, 1, 4'b0011, 0, 4'b1010, 1, 0, 4'b1010, 1, 2'b10);
    vecs[28] = mk(0, 1, 4'b0011, 0, 4'b1010, 0, 0, 4'b1010, 0, 2'b10);
    vecs[29] = mk(0, 1, 4'b0011, 0, 4'b0110, 0, 0, 4'b0110, 0, 2'b10);
    vecs[30] = mk(0, 0, 4'b0011, 0, 4'b0110, 0, 1, 4'b0110, 0, 2'b00);
    vecs[31] = mk(0, 0, 4'b0011, 0, 4'b0110, 0, 0, 4'b0110, 0, 2'b00);
    vecs[32] = mk(0, 0, 4'b0011, 0, 4'b0110, 0, 1, 4'b0011, 1, 2'b00);
    vecs[33] = mk(0, 0, 4'b0011, 0, 4'b0110, 0, 0, 4'b0011, 1, 2'b00);
    vecs[34] = mk(0, 0, 4'b0011, 0, 4'b0110, 0, 0, 4'b0011, 1, 2'b00);
    vecs[35] = mk(0, 0, 4'b0011, 0, 4'b0110, 0, 0, 4'b0011, 1, 2'b00);
    vecs[36] = mk(0, 0, 4'b0011, 0, 4'b0110, 0, 0, 4'b0011, 0, 2'b01);

    #2;
    phase = "table";
    step_idx = 0;
    for (int i = 0; i < 37; i++) begin
      runVec(vecs[i]);
    end

    // Drain with i_valid held low must run to the timeout count before flushing.
    phase = "drain_timeout";
    step_idx = 0;
    for (int i = 0; i < 1024; i++) begin
      runVec(mk(0, 1, 4'b0011, 0, 4'b1100, 0, 0, 4'b0011, 0, 2'b00));
    end
    for (int i = 0; i < 4; i++) begin
      runVec(mk(0, 1, 4'b0011, 0, 4'b1100, 0, 0, 4'b1100, 1, 2'b00));
    end
    runVec(mk(0, 1, 4'b0011, 0, 4'b1100, 0, 0, 4'b1100, 0, 2'b10));

    // Select toggles during drain and flush do not abort; flush o_sw follows sel.
    phase = "sel_toggle";
    step_idx = 0;
    runVec(mk(0, 0, 4'b0011, 0, 4'b1100, 0, 0, 4'b1100, 0, 2'b00));
    runVec(mk(0, 1, 4'b0011, 0, 4'b1100, 0, 0, 4'b1100, 0, 2'b00));
    runVec(mk(0, 1, 4'b0011, 0, 4'b1100, 0, 0, 4'b1100, 0, 2'b00));
    runVec(mk(0, 0, 4'b0011, 0, 4'b1100, 0, 1, 4'b0011, 1, 2'b00));
    runVec(mk(0, 1, 4'b0011, 0, 4'b1100, 0, 0, 4'b1100, 1, 2'b00));
    runVec(mk(0, 0, 4'b0011, 0, 4'b1100, 0, 0, 4'b0011, 1, 2'b00));
    runVec(mk(0, 0, 4'b0011, 0, 4'b1100, 0, 0, 4'b0011, 1, 2'b00));
    runVec(mk(0, 0, 4'b0011, 0, 4'b1100, 0, 0, 4'b0011, 0, 2'b01));

    // Reset in the middle of a flush restarts the full flush with grant held at 00.
    phase = "reset_in_flush";
    step_idx = 0;
    runVec(mk(0, 1, 4'b0011, 0, 4'b1001, 0, 0, 4'b0011, 0, 2'b00));
    runVec(mk(0, 1, 4'b0011, 0, 4'b1001, 0, 1, 4'b1001, 1, 2'b00));
    runVec(mk(0, 1, 4'b0011, 0, 4'b1001, 0, 0, 4'b1001, 1, 2'b00));
    runVec(mk(1, 1, 4'b0011, 0, 4'b1001, 0, 0, 4'b0000, 1, 2'b00));
    runVec(mk(0, 1, 4'b0011, 0, 4'b1001, 0, 0, 4'b1001, 1, 2'b00));
    runVec(mk(0, 1, 4'b0011, 0, 4'b1001, 0, 0, 4'b1001, 1, 2'b00));
    runVec(mk(0, 1, 4'b0011, 0, 4'b1001, 0, 0, 4'b1001, 1, 2'b00));
    runVec(mk(0, 1, 4'b0011, 0, 4'b1001, 0, 0, 4'b1001, 0, 2'b10));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
